player_collide_seq: RTL and testbench
=====================================

# player_collide_seq

Per-frame collision sequencer for the player. On each frame tick it computes the player's candidate next position and probes the four corner tiles through the shared single-port tile-map read port, which it shares with the renderer at lower priority. It then presents a 4-bit corner-hit mask and a one-cycle step pulse that advances the player update. It sits between the frame timing generator, the tile map and the player block.

## Interface
- X_ORIGIN, 144, pixel x of playfield column 0
- Y_ORIGIN, 35, pixel y of playfield row 0
- TILE_SHIFT, 5, log2 of the tile size (32 px)
- MAP_COLS, 20, tiles per row
- MAP_ROWS, 15, tile rows
- PLAYER_W, 32, player width in px
- PLAYER_H, 32, player height in px
- ADDR_W, 9, tile-map address width
- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame
- player_pos  in  20  {x[19:10], y[9:0]}, unsigned pixel position
- player_dir  in  1  0 = left, 1 = right
- x_speed  in  10  horizontal step in px
- ren_req  in  1  renderer requests the map port this cycle
- ren_addr  in  ADDR_W  renderer read address
- map_addr  out  ADDR_W  tile-map read address
- map_rd  out  1  read strobe; data valid on map_rdata the following cycle
- map_rdata  in  1  1 = solid tile
- player_col  out  4  corner hits: [3] TL, [2] TR, [1] BL, [0] BR
- step  out  1  one-cycle pulse; player_col is valid and the player may update
- busy  out  1  probe sequence in progress
- overrun  out  1  sticky flag: a frame_tick arrived while busy

## Operation
- FSM states: IDLE, LATCH, ISSUE, CAPTURE, DONE.
- IDLE: when frame_tick is high, go to LATCH and raise busy.
- LATCH: register the candidate position.
  - cx = x + x_speed if player_dir = 1, otherwise x − x_speed.
  - cy = y.
  - All arithmetic is 11-bit signed so underflow is detectable.
  - Corner index k = 0.
- Corner points, in order k = 0..3: (cx, cy), (cx+PLAYER_W−1, cy), (cx, cy+PLAYER_H−1), (cx+PLAYER_W−1, cy+PLAYER_H−1).
- Address calculation:
  - col = (px − X_ORIGIN) >> TILE_SHIFT
  - row = (py − Y_ORIGIN) >> TILE_SHIFT
  - addr = row·MAP_COLS + col
- ISSUE:
  - If ren_req = 1: stall in ISSUE. The renderer owns the port: map_addr = ren_addr, map_rd = 1.
  - Otherwise: drive map_addr = addr(k) and map_rd = 1, then go to CAPTURE.
- CAPTURE:
  - Latch map_rdata into hit bit (3 − k).
  - If k < 3: increment k and return to ISSUE. Otherwise go to DONE.
  - The renderer may use the port during CAPTURE.
- DONE: update player_col from the hit bits, pulse step for one cycle, drop busy, and return to IDLE.
- Whenever the probe does not drive the port: map_addr = ren_addr and map_rd = ren_req.
- frame_tick while busy: the tick is ignored and overrun is set. overrun is cleared only by rst.
- rst in any state:
  - Return to IDLE and abandon any in-flight probe; no step pulse is issued.
  - All outputs go to 0: player_col, step, busy, map_rd, map_addr, overrun.

## Timing
- frame_tick is sampled in cycle T. LATCH occurs in T+1, and the corner-0 ISSUE in T+2.
- Without contention, each corner takes 2 cycles: CAPTURE for corner 3 is in T+9, and DONE/step is in T+10.
- busy is high from T+1 through T+10 inclusive.
- Each renderer-stalled cycle adds exactly one cycle of latency.
- player_col holds its value between DONE events.
- step is never asserted for two consecutive cycles.

## Configuration
- BOUNDS_CHECK_EN defined:
  - A corner is out of field if px < X_ORIGIN, py < Y_ORIGIN, col ≥ MAP_COLS, or row ≥ MAP_ROWS.
  - An out-of-field corner forces its hit bit to 1 and issues no read: map_rd = 0 for that ISSUE.
  - Its ISSUE/CAPTURE still take 2 cycles, so latency stays deterministic. It still waits for ren_req = 0.
- BOUNDS_CHECK_EN undefined: no range check. The address is truncated to ADDR_W and always read.

## Structure
- Shared package collide_pkg holds:
  - FSM state encoding
  - corner index constants (CORNER_TL = 3, CORNER_TR = 2, CORNER_BL = 1, CORNER_BR = 0)
  - default geometry constants (144, 35, 5, 20, 15)
- One sub-module, tile_addr_calc: combinational, (px, py) → (addr, oob). It is instantiated once and muxed by k.

## Test plan
- Defaults, x = 200, y = 300, dir = 1, speed = 3, empty map, ren_req = 0 → map_addr sequence 161, 162, 181, 182; step at T+10; player_col = 0000.
- Same stimulus, map solid only at address 162 → player_col = 0100; step at T+10.
- ren_req held high during T+2..T+6 → no probe map_rd in that window (map_addr = ren_addr); step at T+15; player_col unchanged from the no-contention result.
- x = 145, dir = 0, speed = 3, BOUNDS_CHECK_EN defined → corners TL and BL out of field: player_col = 1010; only 2 probe reads issued; step at T+10.
- Second frame_tick at T+5 → overrun = 1 from T+6 onward; exactly one step, at T+10.
- rst asserted at T+6 → at T+7 all outputs are 0 and busy = 0; no step for that frame; the next frame_tick runs a full sequence.

Source files
------------

// File: rtl/collide_pkg.sv
// collide_pkg: shared FSM encoding, corner indices and default playfield geometry
package collide_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ISSUE, S_CAPTURE, S_DONE} state_t;
    localparam int CORNER_TL = 3;
    localparam int CORNER_TR = 2;
    localparam int CORNER_BL = 1;
    localparam int CORNER_BR = 0;
    localparam int DEF_X_ORIGIN = 144;
    localparam int DEF_Y_ORIGIN = 35;
    localparam int DEF_TILE_SHIFT = 5;
    localparam int DEF_MAP_COLS = 20;
    localparam int DEF_MAP_ROWS = 15;
endpackage

// File: rtl/tile_addr_calc.sv
// tile_addr_calc: maps a signed pixel point to a tile-map address and an out-of-field flag
module tile_addr_calc
    import collide_pkg::*;
#(
    parameter int X_ORIGIN = DEF_X_ORIGIN,
    parameter int Y_ORIGIN = DEF_Y_ORIGIN,
    parameter int TILE_SHIFT = DEF_TILE_SHIFT,
    parameter int MAP_COLS = DEF_MAP_COLS,
    parameter int MAP_ROWS = DEF_MAP_ROWS,
    parameter int ADDR_W = 9,
    parameter bit BOUNDS = 1'b0
) (
    input  logic signed [10:0]       px,
    input  logic signed [10:0]       py,
    output logic        [ADDR_W-1:0] addr,
    output logic                     oob
);
    localparam logic signed [10:0] XO = 11'(X_ORIGIN);
    localparam logic signed [10:0] YO = 11'(Y_ORIGIN);
    localparam logic signed [10:0] MC = 11'(MAP_COLS);
    localparam logic signed [10:0] MR = 11'(MAP_ROWS);
    logic signed [10:0] dx, dy, col, row;
    always_comb begin
        dx = px - XO;
        dy = py - YO;
        col = dx >>> TILE_SHIFT;
        row = dy >>> TILE_SHIFT;
        addr = ADDR_W'(row * MC + col);
        oob = BOUNDS && (dx[10] || dy[10] || col >= MC || row >= MR);
    end
endmodule

// File: rtl/player_collide_seq.sv
// player_collide_seq: per-frame four-corner tile probe sequencer for the player.
// Define BOUNDS_CHECK_EN to treat out-of-field corners as solid without a map read.
module player_collide_seq
    import collide_pkg::*;
#(
    parameter int X_ORIGIN = DEF_X_ORIGIN,
    parameter int Y_ORIGIN = DEF_Y_ORIGIN,
    parameter int TILE_SHIFT = DEF_TILE_SHIFT,
    parameter int MAP_COLS = DEF_MAP_COLS,
    parameter int MAP_ROWS = DEF_MAP_ROWS,
    parameter int PLAYER_W = 32,
    parameter int PLAYER_H = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic [19:0]       player_pos,
    input  logic              player_dir,
    input  logic [9:0]        x_speed,
    input  logic              ren_req,
    input  logic [ADDR_W-1:0] ren_addr,
    output logic [ADDR_W-1:0] map_addr,
    output logic              map_rd,
    input  logic              map_rdata,
    output logic [3:0]        player_col,
    output logic              step,
    output logic              busy,
    output logic              overrun
);
`ifdef BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    localparam logic signed [10:0] W1 = 11'(PLAYER_W - 1);
    localparam logic signed [10:0] H1 = 11'(PLAYER_H - 1);

    state_t state, nxt;
    logic [1:0] k;
    logic signed [10:0] cx, cy, px, py;
    logic [3:0] hits, col_q;
    logic [ADDR_W-1:0] addr;
    logic oob;

    // k[0] selects the right edge, k[1] the bottom edge
    assign px = cx + (k[0] ? W1 : 11'sd0);
    assign py = cy + (k[1] ? H1 : 11'sd0);

    tile_addr_calc #(
        .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .TILE_SHIFT(TILE_SHIFT),
        .MAP_COLS(MAP_COLS), .MAP_ROWS(MAP_ROWS), .ADDR_W(ADDR_W), .BOUNDS(BOUNDS)
    ) u_calc (
        .px(px),
        .py(py),
        .addr(addr),
        .oob(oob)
    );

    assign busy = state != S_IDLE;
    assign step = state == S_DONE;
    assign player_col = step ? hits : col_q;

    always_comb begin
        nxt = state;
        map_addr = ren_addr;
        map_rd = ren_req;
        case (state)
            S_IDLE:    nxt = frame_tick ? S_LATCH : S_IDLE;
            S_LATCH:   nxt = S_ISSUE;
            S_ISSUE: begin
                if (!ren_req) begin
                    map_addr = addr;
                    map_rd = !oob;
                    nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: nxt = (k == 2'd3) ? S_DONE : S_ISSUE;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k <= 2'd0;
            cx <= 11'sd0;
            cy <= 11'sd0;
            hits <= 4'd0;
            col_q <= 4'd0;
            overrun <= 1'b0;
        end else begin
            state <= nxt;
            if (frame_tick && busy)
                overrun <= 1'b1;
            if (state == S_LATCH) begin
                cx <= player_dir ? $signed({1'b0, player_pos[19:10]}) + $signed({1'b0, x_speed})
                                 : $signed({1'b0, player_pos[19:10]}) - $signed({1'b0, x_speed});
                cy <= $signed({1'b0, player_pos[9:0]});
                k <= 2'd0;
            end
            // corner k lands in bit 3-k, so TL ends up in bit 3
            if (state == S_CAPTURE) begin
                hits[~k] <= oob | map_rdata;
                k <= k + 2'd1;
            end
            if (state == S_DONE)
                col_q <= hits;
        end
    end
endmodule

// File: tb/tb_player_collide_seq.sv
// tb_player_collide_seq: directed self-checking bench for player_collide_seq
module tb_player_collide_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_tick = 1'b0;
    logic [19:0] player_pos = 20'd0;
    logic player_dir = 1'b0;
    logic [9:0] x_speed = 10'd0;
    logic ren_req = 1'b0;
    logic [8:0] ren_addr = 9'd0;
    logic [8:0] map_addr;
    logic map_rd;
    logic map_rdata = 1'b0;
    logic [3:0] player_col;
    logic step, busy, overrun;
    logic [8:0] solid = 9'd511;
    int checks = 0;
    int errors = 0;
    logic st [0:24];
    logic bz [0:24];
    logic ov [0:24];
    logic rd [0:24];
    logic rq [0:24];
    logic [8:0] ad [0:24];
    logic [3:0] cl [0:24];
    int nsteps, step_at, nreads;
    logic [8:0] raddr [0:7];

    player_collide_seq dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .player_pos(player_pos),
        .player_dir(player_dir), .x_speed(x_speed), .ren_req(ren_req), .ren_addr(ren_addr),
        .map_addr(map_addr), .map_rd(map_rd), .map_rdata(map_rdata), .player_col(player_col),
        .step(step), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // one-cycle-latency map with a single solid tile
    always @(posedge clk) map_rdata <= map_rd && (map_addr == solid);

    task automatic sample(input int c);
        st[c] = step; bz[c] = busy; ov[c] = overrun; rd[c] = map_rd;
        rq[c] = ren_req; ad[c] = map_addr; cl[c] = player_col;
    endtask

    // cycle 0 carries frame_tick; ren_req is high in cycles lo..hi
    task automatic run_frame(input int lo, input int hi, input int t2, input int ra, input int ncyc);
        @(posedge clk); #1;
        frame_tick = 1'b1; ren_req = 1'b0; rst = 1'b0;
        #1 sample(0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            frame_tick = (c == t2);
            ren_req = (c >= lo && c <= hi);
            rst = (c == ra);
            #1 sample(c);
        end
        @(posedge clk); #1;
        frame_tick = 1'b0; ren_req = 1'b0; rst = 1'b0;
        nsteps = 0; step_at = -1; nreads = 0;
        for (int c = 0; c <= ncyc; c++) begin
            if (st[c] === 1'b1) begin
                nsteps++;
                if (step_at < 0) step_at = c;
            end
            if (rd[c] === 1'b1 && !rq[c]) begin
                if (nreads < 8) raddr[nreads] = ad[c];
                nreads++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b want 0", step); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        checks++; if (player_col !== 4'd0) begin errors++; $display("FAIL reset_col got %b want 0000", player_col); end
        checks++; if (map_rd !== 1'b0 || map_addr !== 9'd0) begin errors++; $display("FAIL reset_port got rd=%b addr=%0d want 0/0", map_rd, map_addr); end
    endtask

    task automatic test_basic;
        logic [8:0] e [0:3];
        logic bad;
        e[0] = 9'd161; e[1] = 9'd162; e[2] = 9'd181; e[3] = 9'd182;
        player_pos = {10'd200, 10'd300}; player_dir = 1'b1; x_speed = 10'd3; solid = 9'd511;
        run_frame(-1, -1, -1, -1, 14);
        checks++; if (nreads !== 4) begin errors++; $display("FAIL basic_reads got %0d want 4", nreads); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (raddr[i] !== e[i]) begin errors++; $display("FAIL basic_addr%0d got %0d want %0d", i, raddr[i], e[i]); end
        end
        checks++; if (nsteps !== 1 || step_at !== 10) begin errors++; $display("FAIL basic_step got n=%0d at=%0d want 1 at 10", nsteps, step_at); end
        bad = bz[0] !== 1'b0 || bz[11] !== 1'b0;
        for (int c = 1; c <= 10; c++) if (bz[c] !== 1'b1) bad = 1'b1;
        checks++; if (bad) begin errors++; $display("FAIL basic_busy got b0=%b b1=%b b10=%b b11=%b want 0110", bz[0], bz[1], bz[10], bz[11]); end
        checks++; if (cl[10] !== 4'b0000) begin errors++; $display("FAIL basic_col got %b want 0000", cl[10]); end
    endtask

    task automatic test_solid;
        solid = 9'd162;
        run_frame(-1, -1, -1, -1, 14);
        checks++; if (cl[10] !== 4'b0100) begin errors++; $display("FAIL solid_col got %b want 0100", cl[10]); end
        checks++; if (nsteps !== 1 || step_at !== 10) begin errors++; $display("FAIL solid_step got n=%0d at=%0d want 1 at 10", nsteps, step_at); end
        checks++; if (cl[13] !== 4'b0100) begin errors++; $display("FAIL solid_hold got %b want 0100", cl[13]); end
    endtask

    task automatic test_stall;
        logic bad;
        ren_addr = 9'd400;
        run_frame(2, 6, -1, -1, 20);
        bad = 1'b0;
        for (int c = 2; c <= 6; c++) if (rd[c] !== 1'b1 || ad[c] !== 9'd400) bad = 1'b1;
        checks++; if (bad) begin errors++; $display("FAIL stall_window got rd2=%b addr2=%0d want 1/400", rd[2], ad[2]); end
        checks++; if (nsteps !== 1 || step_at !== 15) begin errors++; $display("FAIL stall_step got n=%0d at=%0d want 1 at 15", nsteps, step_at); end
        checks++; if (cl[15] !== 4'b0100) begin errors++; $display("FAIL stall_col got %b want 0100", cl[15]); end
        checks++; if (nreads !== 4 || raddr[0] !== 9'd161) begin errors++; $display("FAIL stall_reads got n=%0d a0=%0d want 4/161", nreads, raddr[0]); end
        ren_addr = 9'd0;
    endtask

    task automatic test_bounds;
        player_pos = {10'd145, 10'd300}; player_dir = 1'b0; solid = 9'd511;
        run_frame(-1, -1, -1, -1, 14);
`ifdef BOUNDS_CHECK_EN
        checks++; if (cl[10] !== 4'b1010) begin errors++; $display("FAIL bounds_col got %b want 1010", cl[10]); end
        checks++; if (nreads !== 2) begin errors++; $display("FAIL bounds_reads got %0d want 2", nreads); end
        checks++; if (raddr[0] !== 9'd160 || raddr[1] !== 9'd180) begin errors++; $display("FAIL bounds_addr got %0d,%0d want 160,180", raddr[0], raddr[1]); end
`else
        checks++; if (cl[10] !== 4'b0000) begin errors++; $display("FAIL bounds_col got %b want 0000", cl[10]); end
        checks++; if (nreads !== 4) begin errors++; $display("FAIL bounds_reads got %0d want 4", nreads); end
        checks++; if (raddr[0] !== 9'd159 || raddr[2] !== 9'd179) begin errors++; $display("FAIL bounds_addr got %0d,%0d want 159,179", raddr[0], raddr[2]); end
`endif
        checks++; if (nsteps !== 1 || step_at !== 10) begin errors++; $display("FAIL bounds_step got n=%0d at=%0d want 1 at 10", nsteps, step_at); end
    endtask

    task automatic test_overrun;
        player_pos = {10'd200, 10'd300}; player_dir = 1'b1; solid = 9'd162;
        run_frame(-1, -1, 5, -1, 14);
        checks++; if (ov[5] !== 1'b0) begin errors++; $display("FAIL overrun_early got %b want 0", ov[5]); end
        checks++; if (ov[6] !== 1'b1 || ov[14] !== 1'b1) begin errors++; $display("FAIL overrun_set got %b,%b want 1,1", ov[6], ov[14]); end
        checks++; if (nsteps !== 1 || step_at !== 10) begin errors++; $display("FAIL overrun_step got n=%0d at=%0d want 1 at 10", nsteps, step_at); end
    endtask

    task automatic test_rst_mid;
        run_frame(-1, -1, -1, 6, 14);
        checks++; if (st[7] !== 1'b0 || bz[7] !== 1'b0) begin errors++; $display("FAIL rstmid_ctl got step=%b busy=%b want 0/0", st[7], bz[7]); end
        checks++; if (ov[7] !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got %b want 0", ov[7]); end
        checks++; if (cl[7] !== 4'd0) begin errors++; $display("FAIL rstmid_col got %b want 0000", cl[7]); end
        checks++; if (rd[7] !== 1'b0 || ad[7] !== 9'd0) begin errors++; $display("FAIL rstmid_port got rd=%b addr=%0d want 0/0", rd[7], ad[7]); end
        checks++; if (nsteps !== 0) begin errors++; $display("FAIL rstmid_nostep got %0d want 0", nsteps); end
        run_frame(-1, -1, -1, -1, 14);
        checks++; if (nsteps !== 1 || step_at !== 10) begin errors++; $display("FAIL rstmid_next_step got n=%0d at=%0d want 1 at 10", nsteps, step_at); end
        checks++; if (cl[10] !== 4'b0100 || nreads !== 4) begin errors++; $display("FAIL rstmid_next got col=%b reads=%0d want 0100/4", cl[10], nreads); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_solid;
        test_stall;
        test_bounds;
        test_overrun;
        test_rst_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
